// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, branch
// types and the opcode values the decoder and bench agree on.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_MEM   = 2'd3
  } seq_state_e;

  localparam logic [1:0] BR_Z   = 2'd0;
  localparam logic [1:0] BR_NZ  = 2'd1;
  localparam logic [1:0] BR_JMP = 2'd2;
  localparam logic [1:0] BR_JMR = 2'd3;

  localparam int         OPC_W   = 6;
  localparam logic [5:0] OPC_NOP = 6'h00;
  localparam logic [5:0] OPC_ADD = 6'h01;
  localparam logic [5:0] OPC_LD  = 6'h10;
  localparam logic [5:0] OPC_ST  = 6'h11;
  localparam logic [5:0] OPC_BR  = 6'h20;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[31:32-OPC_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection for the non-memory retire path.
// All arithmetic wraps modulo 2^PC_W.
module fetch_sequencer_next_pc_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            J,
  input  logic [1:0]      B,
  input  logic            offset_sel,
  input  logic [15:0]     im_offset,
  input  logic [PC_W-1:0] jr_target,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_pc;

  assign seq_pc = pc + PC_W'(1);
  // Offset is sign-extended before truncation to PC_W, so negative offsets wrap correctly.
  assign rel_pc = PC_W'($signed({1'b0, pc}) + $signed(im_offset));

  always_comb begin
    next_pc = seq_pc;
    if (J) begin
      case (B)
        BR_Z:    next_pc = zero  ? rel_pc : seq_pc;
        BR_NZ:   next_pc = !zero ? rel_pc : seq_pc;
        BR_JMP:  next_pc = rel_pc;
        BR_JMR:  next_pc = offset_sel ? jr_target : rel_pc;
        default: next_pc = seq_pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle instruction sequencer: owns PC, IR and retire count, fetches
// over a req/ack port and opens execute / memory windows for the datapath.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic             exec_en,
  output logic             mem_en,
  input  logic             mem_op,
  input  logic             mem_done,
  input  logic             J,
  input  logic [1:0]       B,
  input  logic             offset_sel,
  input  logic [15:0]      im_offset,
  input  logic [PC_W-1:0]  jr_target,
  input  logic             zero,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  next_pc;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  fetch_sequencer_next_pc_calc #(
    .PC_W(PC_W)
  ) u_next_pc_calc (
    .pc         (pc_q),
    .J          (J),
    .B          (B),
    .offset_sel (offset_sel),
    .im_offset  (im_offset),
    .jr_target  (jr_target),
    .zero       (zero),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // run is only consulted at instruction boundaries; an in-flight fetch or
  // memory access always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  begin
        if (mem_op) state_d = ST_MEM;
        else        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_MEM:   if (mem_done) state_d = run ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == ST_FETCH);
    exec_en  = (state_q == ST_EXEC);
    mem_en   = (state_q == ST_MEM);
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: if (imem_ack) ir_d = imem_rdata;
      ST_EXEC: begin
        if (!mem_op) begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      ST_MEM: begin
        if (mem_done) begin
          pc_d      = pc_q + PC_W'(1);
          retired_d = retired_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a stepped instruction list drives the
// fetch/decoder/memory side, expected retire results are checked on each retire.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      ir;
  logic             exec_en;
  logic             mem_en;
  logic             mem_op;
  logic             mem_done;
  logic             J;
  logic [1:0]       B;
  logic             offset_sel;
  logic [15:0]      im_offset;
  logic [PC_W-1:0]  jr_target;
  logic             zero;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic [CNT_W-1:0] retired;

  fetch_sequencer #(
    .PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .exec_en(exec_en), .mem_en(mem_en), .mem_op(mem_op), .mem_done(mem_done),
    .J(J), .B(B), .offset_sel(offset_sel), .im_offset(im_offset), .jr_target(jr_target),
    .zero(zero), .pc(pc), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        j;
    logic [1:0]  b;
    logic        osel;
    logic [15:0] off;
    logic [7:0]  jrt;
    logic        z;
    logic        mem;
    int          fwait;
    int          mwait;
    logic        drop_run;
    logic [7:0]  exp_pc;
  } step_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ret;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_ret  = 0;
  logic [7:0]  cur_pc;
  logic [15:0] last_ret;
  step_t steps[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic step_t mk(input logic [31:0] instr, input logic j, input logic [1:0] b,
                               input logic osel, input logic [15:0] off, input logic [7:0] jrt,
                               input logic z, input logic mem, input int fwait, input int mwait,
                               input logic drop_run, input logic [7:0] exp_pc);
    step_t s;
    s.instr = instr; s.j = j; s.b = b; s.osel = osel; s.off = off; s.jrt = jrt; s.z = z;
    s.mem = mem; s.fwait = fwait; s.mwait = mwait; s.drop_run = drop_run; s.exp_pc = exp_pc;
    return s;
  endfunction

  // Scoreboard: every change of the retire counter consumes one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ret <= '0;
    end else if (retired != last_ret) begin
      last_ret <= retired;
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_pc", 32'(pc), 32'(mon_e.pc));
        check_val("sb_retired", 32'(retired), 32'(mon_e.ret));
        $display("retire #%0d: pc=%0d (expected %0d)", retired, pc, mon_e.pc);
      end
    end
  end

  task automatic do_step(input step_t s);
    int k;
    int men;
    int xen;
    k = 0;
    while (!imem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("req_seen", 32'(imem_req), 32'd1);
    check_val("fetch_addr", 32'(imem_addr), 32'(cur_pc));
    repeat (s.fwait) @(negedge clk);
    if (s.fwait > 0) check_val("addr_stable", 32'(imem_addr), 32'(cur_pc));
    J = s.j; B = s.b; offset_sel = s.osel; im_offset = s.off; jr_target = s.jrt;
    zero = s.z; mem_op = s.mem;
    imem_ack = 1'b1; imem_rdata = s.instr;
    exp_ret++;
    sb_q.push_back('{pc: s.exp_pc, ret: 16'(exp_ret)});
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check_val("exec_en", 32'(exec_en), 32'd1);
    check_val("ir", ir, s.instr);
    if (s.mem) begin
      @(negedge clk);
      men = 0; xen = 0;
      for (int i = 1; i <= s.mwait; i++) begin
        if (mem_en)  men++;
        if (exec_en) xen++;
        if (i == s.mwait) begin
          mem_done = 1'b1;
          if (s.drop_run) run = 1'b0;
        end
        @(negedge clk);
      end
      mem_done = 1'b0;
      check_val("mem_en_cycles", 32'(men), 32'(s.mwait));
      check_val("exec_en_in_mem", 32'(xen), 32'd0);
      check_val("mem_en_after", 32'(mem_en), 32'd0);
    end else begin
      @(negedge clk);
      check_val("exec_pulse_end", 32'(exec_en), 32'd0);
    end
    check_val("next_req", 32'(imem_req), 32'(run));
    cur_pc = s.exp_pc;
    $display("step: instr=0x%08h -> pc=%0d", s.instr, s.exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; mem_op = 1'b0;
    mem_done = 1'b0; J = 1'b0; B = '0; offset_sel = 1'b0; im_offset = '0;
    jr_target = '0; zero = 1'b0; cur_pc = '0;

    // Test program: pc before each step is the previous exp_pc.
    steps.push_back(mk({OPC_ADD, 26'h12345}, 0, BR_Z,   0, 16'h0000, 8'h00, 0, 0, 3, 0, 0, 8'd1));
    steps.push_back(mk({OPC_BR,  26'h00001}, 1, BR_JMP, 0, 16'h0004, 8'h00, 0, 0, 0, 0, 0, 8'd5));
    steps.push_back(mk({OPC_BR,  26'h00002}, 1, BR_Z,   0, 16'hFFFD, 8'h00, 1, 0, 1, 0, 0, 8'd2));
    steps.push_back(mk({OPC_BR,  26'h00003}, 1, BR_JMP, 0, 16'h0003, 8'h00, 0, 0, 0, 0, 0, 8'd5));
    steps.push_back(mk({OPC_BR,  26'h00004}, 1, BR_Z,   0, 16'hFFFD, 8'h00, 0, 0, 2, 0, 0, 8'd6));
    steps.push_back(mk({OPC_BR,  26'h00005}, 1, BR_JMP, 0, 16'hFFFF, 8'h00, 0, 0, 0, 0, 0, 8'd5));
    steps.push_back(mk({OPC_BR,  26'h00006}, 1, BR_NZ,  0, 16'h0004, 8'h00, 0, 0, 0, 0, 0, 8'd9));
    steps.push_back(mk({OPC_BR,  26'h00007}, 1, BR_NZ,  0, 16'h0004, 8'h00, 1, 0, 0, 0, 0, 8'd10));
    steps.push_back(mk({OPC_BR,  26'h00008}, 1, BR_JMR, 1, 16'h0000, 8'd250, 0, 0, 0, 0, 0, 8'd250));
    steps.push_back(mk({OPC_BR,  26'h00009}, 1, BR_JMP, 0, 16'h000A, 8'h00, 0, 0, 1, 0, 0, 8'd4));
    steps.push_back(mk({OPC_BR,  26'h0000A}, 1, BR_JMR, 1, 16'h0000, 8'h40, 0, 0, 0, 0, 0, 8'h40));
    steps.push_back(mk({OPC_BR,  26'h0000B}, 1, BR_JMP, 0, 16'hFFC3, 8'h00, 0, 0, 0, 0, 0, 8'd3));
    steps.push_back(mk({OPC_LD,  26'h0000C}, 0, BR_Z,   0, 16'h0000, 8'h00, 0, 1, 0, 4, 0, 8'd4));
    steps.push_back(mk({OPC_ST,  26'h0000D}, 0, BR_Z,   0, 16'h0000, 8'h00, 0, 1, 1, 2, 1, 8'd5));
    steps.push_back(mk(NOP_INSTR,            0, BR_Z,   0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 8'd6));
    steps.push_back(mk({OPC_BR,  26'h0000E}, 1, BR_JMR, 1, 16'h0000, 8'd255, 0, 0, 0, 0, 0, 8'd255));
    steps.push_back(mk({OPC_ADD, 26'h0000F}, 0, BR_Z,   0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 8'd0));
    steps.push_back(mk({OPC_BR,  26'h00010}, 1, BR_JMP, 0, 16'h0007, 8'h00, 0, 0, 2, 0, 0, 8'd7));

    #1;
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_ir", ir, 32'd0);
    check_val("rst_retired", 32'(retired), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req", 32'(imem_req), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_no_run", 32'(busy), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check_val("idle_to_fetch", 32'(imem_req), 32'd1);

    for (int i = 0; i < 14; i++) do_step(steps[i]);

    // Run was dropped during the ST access: sequencer must now sit in IDLE.
    check_val("drop_busy", 32'(busy), 32'd0);
    check_val("drop_req", 32'(imem_req), 32'd0);
    check_val("drop_pc", 32'(pc), 32'd5);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    check_val("stray_ack_ir", ir, {OPC_ST, 26'h0000D});
    check_val("stray_ack_busy", 32'(busy), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check_val("restart_req", 32'(imem_req), 32'd1);
    check_val("restart_addr", 32'(imem_addr), 32'd5);

    for (int i = 14; i < steps.size(); i++) do_step(steps[i]);

    // Asynchronous reset while a fetch is pending, checked before any clock edge.
    check_val("pre_reset_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_req", 32'(imem_req), 32'd0);
    check_val("async_rst_pc", 32'(pc), 32'd0);
    check_val("async_rst_ir", ir, 32'd0);
    check_val("async_rst_retired", 32'(retired), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
